pipeline_sequencer: RTL and testbench
=====================================

# pipeline_sequencer

Multi-cycle instruction sequencer for the CPU core. It steps every instruction through the five stages IF → ID → EX → MEM → WB, owns the program counter, and advances or redirects it when an instruction retires. Its one-hot stage vector and PC drive the decoder, ALU, bus and writeback logic. The same signals are exported as `debug_pipeline_stage` and `debug_program_counter` for the unit-test checker.

## Interface
- `I_ADDR_WIDTH`, 10, program-counter width in instruction words
- `STAGE_COUNT`, 5, stage vector width; must equal the shared stage count
- `clk`  in  1  core clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold current stage and PC (bus wait, hazard)
- `branch_taken`  in  1  sampled only on the retiring WB cycle; redirect PC
- `branch_target`  in  I_ADDR_WIDTH  next PC when `branch_taken`
- `halt`  in  1  sampled only on the retiring WB cycle; enter HALTED
- `pipeline_stage`  out  STAGE_COUNT  one-hot current stage; all-zero when halted
- `program_counter`  out  I_ADDR_WIDTH  address of the instruction in flight
- `retire`  out  1  high during a WB cycle that completes (WB and not `stall`)
- `halted`  out  1  high in HALTED
- `cycle_count`  out  32  only with `PERF_COUNTERS_EN`
- `instr_retired`  out  32  only with `PERF_COUNTERS_EN`

## Operation
- States: IF, ID, EX, MEM, WB, HALTED. `pipeline_stage` bit index equals the shared stage index.
- Every instruction visits all five stages. MEM is never skipped, including for register-only ops such as LDI and MOV.
- The stage advances one step per cycle when `stall` = 0. When `stall` = 1, the stage, PC and counters (except `cycle_count`) hold.
- Retire happens in WB when `stall` = 0. On retire:
  - `halt` = 1: go to HALTED; PC holds at the halting instruction.
  - else `branch_taken` = 1: PC ← `branch_target`; next stage IF.
  - else: PC ← PC + 1, modulo 2^I_ADDR_WIDTH (wraps to 0); next stage IF.
- Priority: `reset` > `stall` > `halt` > `branch_taken` > increment.
- `branch_taken`, `branch_target` and `halt` are ignored outside the retiring WB cycle.
- HALTED is left only by `reset`. While halted, `stall` has no effect and `retire` = 0.
- Reset values: stage = IF (`pipeline_stage` = 5'b00001), PC = 0, `retire` = 0, `halted` = 0, counters = 0.
- Reset asserted mid-instruction or in HALTED aborts immediately; no partial retire is recorded.

## Timing
- Unstalled latency is 5 cycles per instruction. The instruction at PC *n* shows IF at cycle 5n after reset release and WB at 5n+4.
- `pipeline_stage`, `program_counter` and `halted` are registered outputs.
- `retire` is combinational from the registered stage and `stall`.
- The PC is stable for all five stages of its instruction and changes on the edge that ends the retiring WB cycle.
- A stall of k cycles in any stage lengthens that instruction by exactly k cycles.

## Configuration
- `PERF_COUNTERS_EN` defined:
  - `cycle_count` increments on every clock with `reset` low and not HALTED, stalls included.
  - `instr_retired` increments on each `retire`, including the halting instruction.
  - Both wrap at 2^32.
- `PERF_COUNTERS_EN` undefined: both ports and their logic are absent. Sequencing is otherwise identical.

## Structure
- The shared defines hold `STAGE_COUNT` and the stage indices `STAGE_IF`/`STAGE_ID`/`STAGE_EX`/`STAGE_MEM`/`STAGE_WB` as one-hot constants. No local copies.
- HALTED is an internal encoding only and is not exported as a stage constant.
- One sub-module, `sequencer_perf_counters`: the two 32-bit counters. It is instantiated only under `PERF_COUNTERS_EN`.

## Test plan
- Reset release with no stall for 15 cycles → stages IF, ID, EX, MEM, WB repeat 3 times; PC = 0, 1, 2; `retire` high in cycles 4, 9 and 14.
- `stall` high for 3 cycles during the MEM of PC 1 → MEM lasts 4 cycles; PC 1 retires at cycle 12; `cycle_count` = 13 and `instr_retired` = 2 after that edge.
- At WB of PC 2 with `branch_taken` = 1, `branch_target` = 0x3F0 → next IF has PC = 0x3F0. `branch_taken` pulsed during EX has no effect.
- PC = 0x3FF retires with no branch → PC wraps to 0x000; stage goes to IF.
- `halt` and `branch_taken` both high at WB of PC 5 → `halted` = 1, `pipeline_stage` = 0, PC stays 5, counters freeze. It stays halted for 20 cycles despite `stall` toggling.
- `reset` asserted asynchronously mid-EX of PC 7 → outputs go to IF, PC 0, counters 0 without waiting for a clock edge. The sequence restarts cleanly on release.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// pipeline_sequencer_pkg: shared stage count, one-hot stage constants and sequencer state encoding.
package pipeline_sequencer_pkg;
  localparam int STAGE_COUNT = 5;
  localparam logic [STAGE_COUNT-1:0] STAGE_IF  = 5'b00001;
  localparam logic [STAGE_COUNT-1:0] STAGE_ID  = 5'b00010;
  localparam logic [STAGE_COUNT-1:0] STAGE_EX  = 5'b00100;
  localparam logic [STAGE_COUNT-1:0] STAGE_MEM = 5'b01000;
  localparam logic [STAGE_COUNT-1:0] STAGE_WB  = 5'b10000;
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALTED} seq_state_t;
endpackage

// File: rtl/pipeline_sequencer_perf_counters.sv
// sequencer_perf_counters: free-running cycle and retired-instruction counters, both wrapping at 2^32.
module sequencer_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_count_en,
  input  logic        i_retire,
  output logic [31:0] o_cycle_count,
  output logic [31:0] o_instr_retired
);
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_retired;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count   <= '0;
      r_instr_retired <= '0;
    end else begin
      if (i_count_en) r_cycle_count <= r_cycle_count + 32'd1;
      if (i_retire) r_instr_retired <= r_instr_retired + 32'd1;
    end
  end
  assign o_cycle_count   = r_cycle_count;
  assign o_instr_retired = r_instr_retired;
endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: steps each instruction through IF/ID/EX/MEM/WB and owns the PC.
// Optional counters (cycle_count, instr_retired) exist only when PERF_COUNTERS_EN is defined.
module pipeline_sequencer #(
  parameter int I_ADDR_WIDTH = 10,
  parameter int STAGE_COUNT  = pipeline_sequencer_pkg::STAGE_COUNT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [I_ADDR_WIDTH-1:0] branch_target,
  input  logic                    halt,
  output logic [STAGE_COUNT-1:0]  pipeline_stage,
  output logic [I_ADDR_WIDTH-1:0] program_counter,
  output logic                    retire,
  output logic                    halted
`ifdef PERF_COUNTERS_EN
  ,
  output logic [31:0]             cycle_count,
  output logic [31:0]             instr_retired
`endif
);
  import pipeline_sequencer_pkg::*;
  seq_state_t              r_state;
  logic [STAGE_COUNT-1:0]  r_stage;
  logic [I_ADDR_WIDTH-1:0] r_pc;
  logic                    r_halted;
  logic                    w_retire;
  assign w_retire = (r_state == S_WB) && !stall;
  // HALTED ignores stall and is only left through reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IF;
      r_stage  <= STAGE_IF;
      r_pc     <= '0;
      r_halted <= 1'b0;
    end else if (r_state != S_HALTED && !stall) begin
      case (r_state)
        S_IF: begin
          r_state <= S_ID;
          r_stage <= STAGE_ID;
        end
        S_ID: begin
          r_state <= S_EX;
          r_stage <= STAGE_EX;
        end
        S_EX: begin
          r_state <= S_MEM;
          r_stage <= STAGE_MEM;
        end
        S_MEM: begin
          r_state <= S_WB;
          r_stage <= STAGE_WB;
        end
        S_WB: begin
          if (halt) begin
            r_state  <= S_HALTED;
            r_stage  <= '0;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_IF;
            r_stage <= STAGE_IF;
            r_pc    <= branch_taken ? branch_target : r_pc + I_ADDR_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end
  assign pipeline_stage  = r_stage;
  assign program_counter = r_pc;
  assign retire          = w_retire;
  assign halted          = r_halted;
`ifdef PERF_COUNTERS_EN
  sequencer_perf_counters u_perf (
    .clk             (clk),
    .reset           (reset),
    .i_count_en      (!r_halted),
    .i_retire        (w_retire),
    .o_cycle_count   (cycle_count),
    .o_instr_retired (instr_retired)
  );
`endif
endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed scenarios plus random stimulus against a behavioural sequencer model.
module tb_pipeline_sequencer;
  localparam int AW = 10;
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          branch_taken = 1'b0;
  logic          halt = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic [4:0]    pipeline_stage;
  logic [AW-1:0] program_counter;
  logic          retire;
  logic          halted;
`ifdef PERF_COUNTERS_EN
  logic [31:0]   cycle_count;
  logic [31:0]   instr_retired;
`endif

  pipeline_sequencer #(.I_ADDR_WIDTH(AW), .STAGE_COUNT(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .halt            (halt),
    .pipeline_stage  (pipeline_stage),
    .program_counter (program_counter),
    .retire          (retire),
    .halted          (halted)
`ifdef PERF_COUNTERS_EN
    ,
    .cycle_count     (cycle_count),
    .instr_retired   (instr_retired)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  // model: position within the current instruction (0=IF..4=WB), PC, halted flag, counters
  int          m_pos;
  logic        m_halted;
  logic [AW-1:0] m_pc;
  logic [31:0] m_cyc;
  logic [31:0] m_ret;
  int          cyc_n;
  logic [31:0] retire_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] exp_stage();
    return m_halted ? 5'd0 : 5'(1 << m_pos);
  endfunction

  task automatic check_regs();
    chk("stage", 32'(pipeline_stage), 32'(exp_stage()));
    chk("pc", 32'(program_counter), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halted));
`ifdef PERF_COUNTERS_EN
    chk("cycle_count", cycle_count, m_cyc);
    chk("instr_retired", instr_retired, m_ret);
`endif
  endtask

  task automatic cycle(input logic s, input logic bt, input logic [AW-1:0] tgt, input logic h);
    logic r;
    @(negedge clk);
    stall = s;
    branch_taken = bt;
    branch_target = tgt;
    halt = h;
    #1;
    r = !m_halted && m_pos == 4 && !s;
    chk("retire", 32'(retire), 32'(r));
    if (r && cyc_n < 32) retire_mask[cyc_n] = 1'b1;
    @(posedge clk);
    if (!m_halted) m_cyc++;
    if (r) begin
      m_ret++;
      if (h) m_halted = 1'b1;
      else begin
        m_pc = bt ? tgt : m_pc + 1'b1;
        m_pos = 0;
      end
    end else if (!m_halted && !s) m_pos++;
    cyc_n++;
    #1 check_regs();
  endtask

  // reset lands between clock edges so the checks prove it acts without an edge
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    halt = 1'b0;
    #1;
    m_pos = 0;
    m_halted = 1'b0;
    m_pc = '0;
    m_cyc = '0;
    m_ret = '0;
    check_regs();
    chk("rst_stage_lit", 32'(pipeline_stage), 32'h1);
    chk("rst_pc_lit", 32'(program_counter), 32'h0);
    chk("rst_retire", 32'(retire), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc_n = 0;
    retire_mask = '0;
  endtask

  initial begin
    do_reset();
    repeat (15) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("retire_cycles_15", retire_mask, 32'h4210);
    chk("pc_after_3", 32'(program_counter), 32'h3);

    do_reset();
    for (int c = 0; c < 13; c++) cycle(c >= 8 && c <= 10, 1'b0, '0, 1'b0);
    chk("retire_cycles_stall", retire_mask, 32'h1010);
    chk("pc_after_stall", 32'(program_counter), 32'h2);
`ifdef PERF_COUNTERS_EN
    chk("cycle_count_13", cycle_count, 32'd13);
    chk("instr_retired_2", instr_retired, 32'd2);
`endif
    for (int c = 13; c < 18; c++)
      cycle(1'b0, c == 15 || c == 17, c == 17 ? AW'(10'h3F0) : AW'(10'h100), 1'b0);
    chk("branch_pc", 32'(program_counter), 32'h3F0);
    chk("branch_stage", 32'(pipeline_stage), 32'h1);

    repeat (80) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("wrap_pc", 32'(program_counter), 32'h0);
    chk("wrap_stage", 32'(pipeline_stage), 32'h1);

    repeat (29) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, AW'(10'h155), 1'b1);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_stage", 32'(pipeline_stage), 32'h0);
    chk("halt_pc", 32'(program_counter), 32'h5);
    for (int c = 0; c < 20; c++) cycle(c[0], 1'($urandom), AW'($urandom), 1'($urandom));
    chk("still_halted", 32'(halted), 32'h1);
    chk("still_pc5", 32'(program_counter), 32'h5);

    do_reset();
    repeat (37) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("ex_of_pc7_stage", 32'(pipeline_stage), 32'h4);
    chk("ex_of_pc7_pc", 32'(program_counter), 32'h7);
    do_reset();
    repeat (6) cycle(1'b0, 1'b0, '0, 1'b0);
    chk("restart_pc", 32'(program_counter), 32'h1);

    for (int n = 0; n < 3000; n++) begin
      if ((m_halted && $urandom_range(19) == 0) || $urandom_range(299) == 0) do_reset();
      else cycle($urandom_range(3) == 0, 1'($urandom), AW'($urandom), $urandom_range(49) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
